script_branch_unit: RTL and testbench
=====================================

# script_branch_unit

Parametrised branch/wait unit for the kitchen script sequencer. It accepts one branch request per instruction and evaluates a selected kitchen feedback bit. It supports conditional and unconditional signed-offset jumps, plus a blocking wait-for-signal mode with an optional timeout. It sits between the instruction decoder and the PC register, and returns a resolved `next_pc` with a one-cycle valid pulse.

## Interface

Parameters:
- `PC_W`, 8, width of program counter.
- `OFF_W`, 8, width of `i_num`, a two's-complement line offset.
- `SIG_W`, 8, width of `feedback_sig`.
- `STEP`, 2, PC increment per script line.
- `TIMEOUT`, 1000, wait-mode timeout in cycles (used only with `BRANCH_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  request strobe, sampled when `busy`=0.
- `func`  in  2  mode: 00 jumpif, 01 jumpifn, 10 jump (unconditional), 11 waitif.
- `i_num`  in  OFF_W  signed line offset.
- `i_sign`  in  $clog2(SIG_W)  index into `feedback_sig`.
- `current_pc`  in  PC_W  PC of the branch instruction.
- `feedback_sig`  in  SIG_W  live kitchen state bits.
- `next_pc`  out  PC_W  resolved PC, held between requests.
- `pc_valid`  out  1  one-cycle pulse when `next_pc` is updated.
- `busy`  out  1  high from the cycle after acceptance until `pc_valid`.
- `timed_out`  out  1  high with `pc_valid` when a wait ended by timeout.

## Operation

- The FSM has states IDLE, EVAL, WAIT, DONE.
- IDLE:
  - When `en`=1, latch `func`, `i_num`, `i_sign`, `current_pc`.
  - func 00/01/10 go to EVAL; func 11 goes to WAIT.
- EVAL:
  - Sample `sig = feedback_sig[i_sign]`. An index ≥ SIG_W reads as 0.
  - taken = sig for 00, !sig for 01, 1 for 10.
  - Go to DONE.
- WAIT:
  - Each cycle, sample `sig`. If sig=1, go to DONE with taken=0.
  - With the timeout compiled in: when the wait counter reaches TIMEOUT−1 with sig still 0, go to DONE with taken=1 and `timed_out`=1.
- DONE:
  - `next_pc` = taken ? `current_pc_l + STEP*sext(i_num_l)` : `current_pc_l`.
  - Assert `pc_valid` for one cycle and return to IDLE.
- PC arithmetic is computed at PC_W bits and wraps modulo 2^PC_W in both directions. Negative offsets give backward jumps.
- `en` while `busy`=1 is ignored and not queued.
- Operands are latched, so input changes after acceptance have no effect. The exception is `feedback_sig`, which is sampled live in EVAL/WAIT.

## Timing

- Reset values: `next_pc`=0, `pc_valid`=0, `busy`=0, `timed_out`=0, state IDLE, wait counter 0.
- Jump modes:
  - `en` sampled at edge N.
  - `busy`=1 from N.
  - `feedback_sig` sampled at edge N+1.
  - `next_pc`/`pc_valid` registered at edge N+2; `busy` falls at the same edge.
  - Fixed latency: 2 cycles.
- waitif:
  - If sig=1 at the first WAIT edge, latency is 2 cycles.
  - Otherwise latency is 1 + k + 1, where k is the number of WAIT cycles.
  - Timeout latency is exactly TIMEOUT+1 cycles from acceptance.
- A new request is accepted on the same edge that `pc_valid` is registered (back-to-back throughput: one jump per 2 cycles).
- Reset mid-request, in any state: immediate return to IDLE with all outputs at reset values. No `pc_valid` is issued for the aborted request.
- `timed_out` is registered with, and clears with, `pc_valid`.

## Configuration

- `BRANCH_TIMEOUT_EN` defined:
  - A wait counter of $clog2(TIMEOUT) bits is present.
  - waitif abandons after TIMEOUT cycles and jumps by `i_num` lines, reporting `timed_out`.
- Undefined:
  - No counter; waitif blocks indefinitely until the selected signal is 1.
  - `timed_out` is tied to 0.

## Test plan

- Reset with `rst_n`=0, then release → all outputs 0, `busy`=0.
- jumpif, pc=0x10, i_num=3, `feedback_sig`[2]=1 → `next_pc`=0x16 with `pc_valid` 2 cycles after `en`; same request with bit=0 → 0x10.
- jumpifn, pc=0x04, i_num=−4 (0xFC) → `next_pc`=0xFC (wrap). Also issue a second `en` while `busy` → ignored, exactly one `pc_valid`.
- waitif, pc=0x20, i_sign=5, bit 5 raised after 7 cycles → `next_pc`=0x20, `timed_out`=0, `pc_valid` at cycle 9.
- waitif with `BRANCH_TIMEOUT_EN`, TIMEOUT=16, bit never set, i_num=5 → `next_pc`=0x2A at cycle 17 with `timed_out`=1. Same case without the macro → no `pc_valid` after 1000 cycles.
- `rst_n` pulsed low during WAIT → outputs 0, IDLE. A following jump request completes normally.

Source files
------------

// File: rtl/script_branch_unit.sv
// script_branch_unit: branch/wait resolver for the kitchen script sequencer.
// Takes one branch request, evaluates a selected feedback bit and returns the
// resolved next_pc with a one-cycle pc_valid pulse.
// Optional feature macro: BRANCH_TIMEOUT_EN adds a timeout to waitif.
module script_branch_unit #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned OFF_W   = 8,
    parameter int unsigned SIG_W   = 8,
    parameter int unsigned STEP    = 2,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic [1:0]                             func,
    input  logic [OFF_W-1:0]                       i_num,
    input  logic [((SIG_W > 1) ? $clog2(SIG_W) : 1)-1:0] i_sign,
    input  logic [PC_W-1:0]                        current_pc,
    input  logic [SIG_W-1:0]                       feedback_sig,
    output logic [PC_W-1:0]                        next_pc,
    output logic                                   pc_valid,
    output logic                                   busy,
    output logic                                   timed_out
);

    localparam int unsigned IdxW = (SIG_W > 1) ? $clog2(SIG_W) : 1;

    typedef enum logic [1:0] {StIdle, StEval, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        func_q, func_d;
    logic [OFF_W-1:0]  num_q, num_d;
    logic [IdxW-1:0]   sign_q, sign_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              taken_q, taken_d;
    logic              tmo_q, tmo_d;
    logic [PC_W-1:0]   next_pc_q, next_pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              busy_q, busy_d;
    logic              timed_out_q, timed_out_d;
    logic              sig;
    logic              accept;
    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   target_pc;

`ifdef BRANCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CntW-1:0]   cnt_q, cnt_d;
`endif

    // Live feedback bit select; an out-of-range index reads as 0.
    always_comb begin
        sig = 1'b0;
        for (int i = 0; i < SIG_W; i++) begin
            if (sign_q == IdxW'(i)) begin
                sig = feedback_sig[i];
            end
        end
    end

    // Jump target, wrapping modulo 2^PC_W; the size cast sign-extends the offset.
    always_comb begin
        off_ext   = PC_W'($signed(num_q));
        target_pc = pc_q + PC_W'(STEP) * off_ext;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        num_d       = num_q;
        sign_d      = sign_q;
        pc_d        = pc_q;
        taken_d     = taken_q;
        tmo_d       = tmo_q;
        next_pc_d   = next_pc_q;
        pc_valid_d  = 1'b0;
        timed_out_d = 1'b0;
        busy_d      = busy_q;
`ifdef BRANCH_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        // DONE also accepts, giving one jump every two cycles.
        accept = en && ((state_q == StIdle) || (state_q == StDone));

        case (state_q)
            StEval: begin
                case (func_q)
                    2'b00:   taken_d = sig;
                    2'b01:   taken_d = ~sig;
                    default: taken_d = 1'b1;
                endcase
                tmo_d   = 1'b0;
                state_d = StDone;
            end
            StWait: begin
                if (sig) begin
                    taken_d = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = StDone;
                end
`ifdef BRANCH_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    taken_d = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StDone: begin
                next_pc_d   = taken_q ? target_pc : pc_q;
                pc_valid_d  = 1'b1;
                timed_out_d = tmo_q;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: ;
        endcase

        if (accept) begin
            func_d  = func;
            num_d   = i_num;
            sign_d  = i_sign;
            pc_d    = current_pc;
            busy_d  = 1'b1;
            state_d = (func == 2'b11) ? StWait : StEval;
`ifdef BRANCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            func_q      <= '0;
            num_q       <= '0;
            sign_q      <= '0;
            pc_q        <= '0;
            taken_q     <= 1'b0;
            tmo_q       <= 1'b0;
            next_pc_q   <= '0;
            pc_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            num_q       <= num_d;
            sign_q      <= sign_d;
            pc_q        <= pc_d;
            taken_q     <= taken_d;
            tmo_q       <= tmo_d;
            next_pc_q   <= next_pc_d;
            pc_valid_q  <= pc_valid_d;
            busy_q      <= busy_d;
            timed_out_q <= timed_out_d;
        end
    end

`ifdef BRANCH_TIMEOUT_EN
    // Wait-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign next_pc   = next_pc_q;
    assign pc_valid  = pc_valid_q;
    assign busy      = busy_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_script_branch_unit.sv
// Directed self-checking bench for script_branch_unit (PC_W=OFF_W=SIG_W=8,
// STEP=2, TIMEOUT=16). Follows BRANCH_TIMEOUT_EN for the timeout scenario.
module tb_script_branch_unit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] func;
    logic [7:0] i_num;
    logic [2:0] i_sign;
    logic [7:0] current_pc;
    logic [7:0] feedback_sig;
    logic [7:0] next_pc;
    logic       pc_valid;
    logic       busy;
    logic       timed_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int pv_count;

    script_branch_unit #(
        .PC_W    (8),
        .OFF_W   (8),
        .SIG_W   (8),
        .STEP    (2),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .func         (func),
        .i_num        (i_num),
        .i_sign       (i_sign),
        .current_pc   (current_pc),
        .feedback_sig (feedback_sig),
        .next_pc      (next_pc),
        .pc_valid     (pc_valid),
        .busy         (busy),
        .timed_out    (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are stable 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One jump-mode request with operand scrambling after acceptance.
    task automatic do_jump(input string tag, input logic [1:0] f, input logic [7:0] num,
                           input logic [2:0] sgn, input logic [7:0] pc,
                           input logic [7:0] fb, input logic [7:0] exp);
        func = f; i_num = num; i_sign = sgn; current_pc = pc; feedback_sig = fb; en = 1'b1;
        tick();
        en = 1'b0; func = ~f; i_num = ~num; i_sign = ~sgn; current_pc = ~pc;
        chk({tag, "_busy_n"}, busy, 1);
        chk({tag, "_pv_n"}, pc_valid, 0);
        tick();
        chk({tag, "_pv_n1"}, pc_valid, 0);
        tick();
        chk({tag, "_pv_n2"}, pc_valid, 1);
        chk({tag, "_pc"}, next_pc, exp);
        chk({tag, "_busy_n2"}, busy, 0);
        chk({tag, "_to"}, timed_out, 0);
        tick();
        chk({tag, "_pv_clr"}, pc_valid, 0);
        chk({tag, "_pc_hold"}, next_pc, exp);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; func = 2'b00; i_num = 8'h00; i_sign = 3'd0;
        current_pc = 8'h00; feedback_sig = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_pc", next_pc, 0);
        chk("rst_pv", pc_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_to", timed_out, 0);

        do_jump("jif_t", 2'b00, 8'd3, 3'd2, 8'h10, 8'h04, 8'h16);
        do_jump("jif_nt", 2'b00, 8'd3, 3'd2, 8'h10, 8'hFB, 8'h10);
        do_jump("jifn_nt", 2'b01, 8'd7, 3'd7, 8'h40, 8'h80, 8'h40);
        do_jump("jmp_wrap", 2'b10, 8'h10, 3'd0, 8'hF0, 8'h00, 8'h10);
        do_jump("jmp_back", 2'b10, 8'hFD, 3'd0, 8'h30, 8'h00, 8'h2A);

        // jumpifn with backward wrap; a second en during EVAL must be ignored.
        func = 2'b01; i_num = 8'hFC; i_sign = 3'd2; current_pc = 8'h04;
        feedback_sig = 8'h00; en = 1'b1;
        tick();
        func = 2'b10; i_num = 8'h55; current_pc = 8'h99;
        tick();
        en = 1'b0;
        chk("jifn_pv_n1", pc_valid, 0);
        tick();
        chk("jifn_pv", pc_valid, 1);
        chk("jifn_pc", next_pc, 8'hFC);
        pv_count = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (pc_valid) pv_count++;
        end
        chk("ignore_pv_count", pv_count, 0);
        chk("ignore_pc_hold", next_pc, 8'hFC);
        chk("ignore_busy", busy, 0);

        // Back-to-back: second request accepted on the pc_valid edge.
        func = 2'b10; i_num = 8'd1; i_sign = 3'd0; current_pc = 8'h00; en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        func = 2'b00; i_num = 8'd2; i_sign = 3'd0; current_pc = 8'h50;
        feedback_sig = 8'h01; en = 1'b1;
        tick();
        en = 1'b0;
        chk("b2b_pv_a", pc_valid, 1);
        chk("b2b_pc_a", next_pc, 8'h02);
        chk("b2b_busy_a", busy, 1);
        tick();
        chk("b2b_pv_gap", pc_valid, 0);
        tick();
        chk("b2b_pv_b", pc_valid, 1);
        chk("b2b_pc_b", next_pc, 8'h54);
        chk("b2b_busy_b", busy, 0);

        // waitif: bit 5 first seen at the 8th edge after acceptance.
        func = 2'b11; i_num = 8'd5; i_sign = 3'd5; current_pc = 8'h20;
        feedback_sig = 8'h00; en = 1'b1;
        tick();
        en = 1'b0; current_pc = 8'h77; i_num = 8'h00;
        pv_count = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 7) feedback_sig = 8'h20;
            if (pc_valid) pv_count++;
        end
        chk("wait_no_early_pv", pv_count, 0);
        chk("wait_busy", busy, 1);
        tick();
        chk("wait_pv", pc_valid, 1);
        chk("wait_pc", next_pc, 8'h20);
        chk("wait_to", timed_out, 0);
        feedback_sig = 8'h00;
        tick();
        chk("wait_pv_clr", pc_valid, 0);

        // waitif with the selected bit never raised.
        func = 2'b11; i_num = 8'd5; i_sign = 3'd5; current_pc = 8'h20; en = 1'b1;
        tick();
        en = 1'b0;
        pv_count = 0;
`ifdef BRANCH_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (pc_valid) pv_count++;
        end
        chk("tmo_no_early_pv", pv_count, 0);
        tick();
        chk("tmo_pv", pc_valid, 1);
        chk("tmo_pc", next_pc, 8'h2A);
        chk("tmo_flag", timed_out, 1);
        tick();
        chk("tmo_flag_clr", timed_out, 0);
        chk("tmo_pv_clr", pc_valid, 0);
        // Start a fresh wait so the reset below lands in WAIT.
        func = 2'b11; i_num = 8'd1; i_sign = 3'd3; current_pc = 8'h60; en = 1'b1;
        tick();
        en = 1'b0;
        for (int c = 0; c < 5; c++) tick();
`else
        for (int c = 1; c <= 1000; c++) begin
            tick();
            if (pc_valid) pv_count++;
        end
        chk("block_no_pv", pv_count, 0);
        chk("block_busy", busy, 1);
        chk("block_to", timed_out, 0);
`endif
        chk("pre_rst_busy", busy, 1);

        // Asynchronous reset while in WAIT.
        rst_n = 1'b0;
        #2;
        chk("mid_rst_pc", next_pc, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pv", pc_valid, 0);
        chk("mid_rst_to", timed_out, 0);
        #1;
        rst_n = 1'b1;
        feedback_sig = 8'hFF;
        pv_count = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (pc_valid) pv_count++;
        end
        chk("abort_no_pv", pv_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pc", next_pc, 0);

        do_jump("post_rst", 2'b00, 8'd3, 3'd1, 8'h10, 8'h02, 8'h16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
